rpll_supervisor: RTL

Sequencing controller for the 60 MHz / 6 MHz rPLL. It pulses the PLL's RESET input after power-up, waits for LOCK to be asserted and stay stable, then releases the downstream system reset. It re-sequences the PLL on lock loss or lock timeout, and latches a fault after repeated failures. It runs on the 27 MHz crystal clock, alongside the PLL wrapper in the top level.

---
 rtl/rpll_supervisor.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rpll_supervisor.sv
// rPLL bring-up sequencer: pulses PLL RESET, qualifies LOCK, releases sys_rst_n, retries on timeout.
// Optional macro RPLL_SUP_LOSS_CNT_EN compiles in the saturating lock-loss counter.
module rpll_supervisor #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_FILTER  = 64,
  parameter int LOCK_TIMEOUT = 27000,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int FW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [RW-1:0] RC_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [FW-1:0] LF_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [TW-1:0] LT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]    MR      = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET, ST_WAIT_LOCK, ST_FILTER, ST_RUN, ST_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic [FW-1:0]   f_q, f_d;
  logic [TW-1:0]   t_q, t_d;
  logic [3:0]      retry_q, retry_d;
  logic            lock_meta_q, lock_meta_d;
  logic            lock_s_q, lock_s_d;
  logic            pll_reset_q, pll_reset_d;
  logic            sys_rst_n_q, sys_rst_n_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;

  always_comb begin
    lock_meta_d = pll_lock;
    lock_s_d    = lock_meta_q;
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    f_d     = f_q;
    t_d     = t_q;
    retry_d = retry_q;
    if (restart) begin
      state_d = ST_RESET;
      rcnt_d  = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          // rcnt is only nonzero inside RESET, so every entry starts a full count
          if (rcnt_q == RC_LAST) begin
            state_d = ST_WAIT_LOCK;
            rcnt_d  = '0;
            t_d     = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (t_q == LT_LAST) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == MR) ? ST_FAULT : ST_RESET;
          end else begin
            t_d = t_q + 1'b1;
            if (lock_s_q) begin
              state_d = ST_FILTER;
              f_d     = '0;
            end
          end
        end
        ST_FILTER: begin
          // filter completion beats a coincident timeout
          if (lock_s_q && f_q == LF_LAST) begin
            state_d = ST_RUN;
          end else if (t_q == LT_LAST) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == MR) ? ST_FAULT : ST_RESET;
          end else if (lock_s_q) begin
            t_d = t_q + 1'b1;
            f_d = f_q + 1'b1;
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_RUN: begin
          if (!lock_s_q) state_d = ST_RESET;
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RESET;
          rcnt_d  = '0;
        end
      endcase
    end
    if (state_d == ST_RUN) retry_d = '0;
  end

  always_comb begin
    pll_reset_d = (state_d == ST_RESET) || (state_d == ST_FAULT);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      rcnt_q      <= '0;
      f_q         <= '0;
      t_q         <= '0;
      retry_q     <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      f_q         <= f_d;
      t_q         <= t_d;
      retry_q     <= retry_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

`ifdef RPLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (!restart && state_q == ST_RUN && !lock_s_q && loss_cnt_q != 8'hFF)
      loss_cnt_d = loss_cnt_q + 8'd1;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) loss_cnt_q <= 8'd0;
    else        loss_cnt_q <= loss_cnt_d;
  end

  assign loss_cnt = loss_cnt_q;
`else
  assign loss_cnt = 8'd0;
`endif

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule
